// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage core: opcode constants, register-index width
// and the hazard unit's state encoding and debug view.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hdu_state_t;

    // Internal state of the hazard unit, exported for checkers.
    typedef struct packed {
        hdu_state_t  state;
        logic [1:0]  bubble_cnt;
        logic        ex_mem_read;
        logic        ex_reg_write;
    } hdu_dbg_t;

endpackage

// File: rtl/hazard_src_decode.sv
// Decodes which source register fields an ID-stage opcode actually reads.
module hazard_src_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_RTYPE, OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and branch flush generation for the 5-stage core, with a shadow of
// the ID/EX destination fields and a saturating stall-cycle counter.
module hazard_detection_unit #(
    parameter int REG_ADDR_W   = riscv_pkg::REG_ADDR_W,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_mem_read,
    input  logic                  id_reg_write,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output riscv_pkg::hdu_dbg_t   dbg
);

    // Extra bubbles after the first one; only meaningful when STALL_CYCLES > 1.
    localparam logic [1:0] BUBBLE_INIT = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 2) : 2'd0;

    riscv_pkg::hdu_state_t state_q, state_d;
    logic [1:0]            bubble_q, bubble_d;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  ex_mem_read_q;
    logic                  ex_reg_write_q;
    logic                  uses_rs1, uses_rs2;
    logic                  hazard;

    hazard_src_decode u_src_decode (
        .opcode   (id_opcode),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    always_comb begin
        hazard = ex_mem_read_q && (ex_rd_q != '0) &&
                 ((uses_rs1 && (ex_rd_q == id_rs1)) || (uses_rs2 && (ex_rd_q == id_rs2)));
    end

    // Flush wins over any stall; the hazard is only evaluated from RUN.
    always_comb begin
        state_d  = state_q;
        bubble_d = bubble_q;
        stall    = 1'b0;
        flush    = ex_branch_taken && !reset;
        if (ex_branch_taken) begin
            state_d  = riscv_pkg::ST_RUN;
            bubble_d = 2'd0;
        end else begin
            case (state_q)
                riscv_pkg::ST_RUN: begin
                    stall = hazard;
                    if (hazard && (STALL_CYCLES > 1)) begin
                        state_d  = riscv_pkg::ST_STALL;
                        bubble_d = BUBBLE_INIT;
                    end
                end
                riscv_pkg::ST_STALL: begin
                    stall = 1'b1;
                    if (bubble_q == 2'd0) begin
                        state_d = riscv_pkg::ST_RUN;
                    end else begin
                        bubble_d = bubble_q - 2'd1;
                    end
                end
                default: begin
                    state_d  = riscv_pkg::ST_RUN;
                    bubble_d = 2'd0;
                end
            endcase
        end
        pc_write   = !stall;
        ifid_write = !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= riscv_pkg::ST_RUN;
            bubble_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    // A stalled or squashed instruction leaves a bubble in the ID/EX shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rd_q        <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else if (stall || flush) begin
            ex_rd_q        <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else begin
            ex_rd_q        <= id_rd;
            ex_mem_read_q  <= id_mem_read;
            ex_reg_write_q <= id_reg_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        dbg.state        = state_q;
        dbg.bubble_cnt   = bubble_q;
        dbg.ex_mem_read  = ex_mem_read_q;
        dbg.ex_reg_write = ex_reg_write_q;
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: two instances (1 and 3 stall cycles) on shared stimulus,
// checked against a cycle-level reference model of the load-use / flush rules.
module tb_hazard_detection_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_mem_read, id_reg_write, ex_branch_taken;

    logic        stall_a, pcw_a, ifw_a, flush_a;
    logic [15:0] cnt_a;
    hdu_dbg_t    dbg_a;
    logic        stall_b, pcw_b, ifw_b, flush_b;
    logic [3:0]  cnt_b;
    hdu_dbg_t    dbg_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int rd;
        bit mem_read;
        bit reg_write;
        int remaining;
        int cnt;
    } mdl_t;

    mdl_t m[2];
    int   bubbles[2] = '{1, 3};
    int   cnt_max[2] = '{65535, 15};

    hazard_detection_unit #(.REG_ADDR_W(5), .STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .ex_branch_taken(ex_branch_taken), .stall(stall_a), .pc_write(pcw_a),
        .ifid_write(ifw_a), .flush(flush_a), .stall_cycles(cnt_a), .dbg(dbg_a)
    );

    hazard_detection_unit #(.REG_ADDR_W(5), .STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .ex_branch_taken(ex_branch_taken), .stall(stall_b), .pc_write(pcw_b),
        .ifid_write(ifw_b), .flush(flush_b), .stall_cycles(cnt_b), .dbg(dbg_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {OPC_RTYPE, OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OPC_RTYPE, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic bit model_stall(input int k);
        bit haz;
        if (reset || ex_branch_taken) return 1'b0;
        if (m[k].remaining > 0) return 1'b1;
        haz = m[k].mem_read && (m[k].rd != 0) &&
              ((reads_rs1(id_opcode) && m[k].rd == int'(id_rs1)) ||
               (reads_rs2(id_opcode) && m[k].rd == int'(id_rs2)));
        return haz;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) m[k] = '{0, 1'b0, 1'b0, 0, 0};
    endtask

    task automatic model_step();
        bit s, f;
        f = ex_branch_taken && !reset;
        for (int k = 0; k < 2; k++) begin
            s = model_stall(k);
            if (reset) begin
                m[k] = '{0, 1'b0, 1'b0, 0, 0};
            end else begin
                if (s && m[k].cnt < cnt_max[k]) m[k].cnt++;
                if (f) m[k].remaining = 0;
                else if (m[k].remaining > 0) m[k].remaining--;
                else if (s) m[k].remaining = bubbles[k] - 1;
                if (s || f) begin
                    m[k].rd = 0; m[k].mem_read = 1'b0; m[k].reg_write = 1'b0;
                end else begin
                    m[k].rd = int'(id_rd); m[k].mem_read = id_mem_read; m[k].reg_write = id_reg_write;
                end
            end
        end
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic check_all();
        bit es, ef;
        logic [15:0] ec;
        for (int k = 0; k < 2; k++) begin
            es = model_stall(k);
            ef = ex_branch_taken && !reset;
            ec = reset ? 16'd0 : 16'(m[k].cnt);
            exp_q.push_back(ec);
            if (k == 0) begin
                check("a stall", 32'(stall_a), 32'(es));
                check("a pc_write", 32'(pcw_a), 32'(!es));
                check("a ifid_write", 32'(ifw_a), 32'(!es));
                check("a flush", 32'(flush_a), 32'(ef));
                check("a stall_cycles", 32'(cnt_a), 32'(exp_q.pop_front()));
                check("a stall_state", 32'(dbg_a.state == ST_STALL), 32'(!reset && m[0].remaining > 0));
                check("a ex_mem_read", 32'(dbg_a.ex_mem_read), 32'(!reset && m[0].mem_read));
                check("a ex_reg_write", 32'(dbg_a.ex_reg_write), 32'(!reset && m[0].reg_write));
            end else begin
                check("b stall", 32'(stall_b), 32'(es));
                check("b pc_write", 32'(pcw_b), 32'(!es));
                check("b ifid_write", 32'(ifw_b), 32'(!es));
                check("b flush", 32'(flush_b), 32'(ef));
                check("b stall_cycles", 32'(cnt_b), 32'(exp_q.pop_front()));
                check("b stall_state", 32'(dbg_b.state == ST_STALL), 32'(!reset && m[1].remaining > 0));
                check("b ex_mem_read", 32'(dbg_b.ex_mem_read), 32'(!reset && m[1].mem_read));
                check("b ex_reg_write", 32'(dbg_b.ex_reg_write), 32'(!reset && m[1].reg_write));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [6:0] op, input int rs1, input int rs2, input int rd,
                         input bit mr, input bit rw, input bit br);
        id_opcode       = op;
        id_rs1          = 5'(rs1);
        id_rs2          = 5'(rs2);
        id_rd           = 5'(rd);
        id_mem_read     = mr;
        id_reg_write    = rw;
        ex_branch_taken = br;
    endtask

    // One clock: drive just after the edge, compare at the falling edge, advance the model.
    task automatic cycle(input logic [6:0] op, input int rs1, input int rs2, input int rd,
                         input bit mr, input bit rw, input bit br);
        drive(op, rs1, rs2, rd, mr, rw, br);
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Reset raised in the second half of a cycle; outputs must change immediately.
    task automatic reset_mid(input logic [6:0] op, input int rs1, input int rs2, input int rd,
                             input bit mr, input bit rw, input bit br);
        drive(op, rs1, rs2, rd, mr, rw, br);
        @(negedge clk);
        check_all();
        #1 reset = 1'b1;
        #1 check_all();
        @(posedge clk);
        model_step();
        #1 reset = 1'b0;
    endtask

    logic [6:0] op_pool[8] = '{OPC_RTYPE, OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE,
                               OPC_BRANCH, 7'b0110111, 7'b1101111};

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        reset = 1'b1;
        drive(OPC_RTYPE, 5, 5, 5, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1 reset = 1'b0;

        // load-use on rs1
        cycle(OPC_LOAD, 1, 0, 5, 1, 1, 0);
        repeat (4) cycle(OPC_RTYPE, 5, 6, 7, 0, 1, 0);
        // x0 destination never hazards
        cycle(OPC_LOAD, 1, 0, 0, 1, 1, 0);
        cycle(OPC_RTYPE, 0, 0, 8, 0, 1, 0);
        // rs2 use: addi ignores rs2 field, store reads it
        cycle(OPC_LOAD, 1, 0, 7, 1, 1, 0);
        cycle(OPC_OPIMM, 3, 7, 8, 0, 1, 0);
        cycle(OPC_LOAD, 1, 0, 7, 1, 1, 0);
        repeat (4) cycle(OPC_STORE, 2, 7, 0, 0, 0, 0);
        // branch squash beats the hazard
        cycle(OPC_LOAD, 1, 0, 5, 1, 1, 0);
        cycle(OPC_RTYPE, 5, 0, 6, 0, 1, 1);
        cycle(OPC_RTYPE, 5, 0, 6, 0, 1, 0);
        // multi-cycle stall ended by a branch in its second cycle
        cycle(OPC_LOAD, 1, 0, 9, 1, 1, 0);
        cycle(OPC_BRANCH, 9, 0, 0, 0, 0, 0);
        cycle(OPC_BRANCH, 9, 0, 0, 0, 0, 1);
        cycle(OPC_BRANCH, 9, 0, 0, 0, 0, 0);
        // reset in the middle of a stall
        cycle(OPC_LOAD, 1, 0, 9, 1, 1, 0);
        cycle(OPC_BRANCH, 9, 0, 0, 0, 0, 0);
        reset_mid(OPC_BRANCH, 9, 0, 0, 0, 0, 0);
        cycle(OPC_BRANCH, 9, 0, 0, 0, 0, 0);
        // back-to-back dependent loads drive the narrow counter into saturation
        cycle(OPC_LOAD, 1, 0, 9, 1, 1, 0);
        repeat (24) cycle(OPC_LOAD, 9, 0, 9, 1, 1, 0);

        // random traffic over a small register window so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            int rs1, rs2, rd;
            bit mr, rw, br;
            op  = op_pool[$urandom_range(0, 7)];
            rs1 = $urandom_range(0, 3);
            rs2 = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            mr  = (op == OPC_LOAD) ? 1'b1 : ($urandom_range(0, 7) == 0);
            rw  = $urandom_range(0, 1);
            br  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 79) == 0) reset_mid(op, rs1, rs2, rd, mr, rw, br);
            else cycle(op, rs1, rs2, rd, mr, rw, br);
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
